pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH slots of {valid, ctrl, data} with stall,
// bubble insertion, flush and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 10,
    parameter int                DEPTH       = 1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16,
    localparam int               OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [OCC_W-1:0]  occ_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              valid_reg [DEPTH];
    logic [CTRL_W-1:0] ctrl_reg  [DEPTH];
    logic [DATA_W-1:0] data_reg  [DEPTH];
    logic [CNT_W-1:0]  cnt_reg;
    logic              bubble_take;

    assign bubble_take = bubble_i & ~flush_i & ~stall_i;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic              v_next;
            logic [CTRL_W-1:0] c_next;
            logic [DATA_W-1:0] d_next;

            if (gi == 0) begin : g_head
                // A bubble drops the incoming entry; an invalid entry is scrubbed
                // so empty slots always carry the no-op control word.
                assign v_next = valid_i & ~bubble_i;
                assign c_next = v_next ? ctrl_i : BUBBLE_CTRL;
                assign d_next = v_next ? data_i : '0;
            end else begin : g_body
                assign v_next = valid_reg[gi-1];
                assign c_next = ctrl_reg[gi-1];
                assign d_next = data_reg[gi-1];
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_reg[gi] <= 1'b0;
                    ctrl_reg[gi]  <= BUBBLE_CTRL;
                    data_reg[gi]  <= '0;
                end else if (flush_i) begin
                    valid_reg[gi] <= 1'b0;
                    ctrl_reg[gi]  <= BUBBLE_CTRL;
                    data_reg[gi]  <= '0;
                end else if (!stall_i) begin
                    valid_reg[gi] <= v_next;
                    ctrl_reg[gi]  <= c_next;
                    data_reg[gi]  <= d_next;
                end
            end
        end
    endgenerate

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (cnt_clr_i) begin
            cnt_reg <= '0;
        end else if (bubble_take && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        occ_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_o = occ_o + OCC_W'(valid_reg[i]);
        end
    end

    assign valid_o      = valid_reg[DEPTH-1];
    assign ctrl_o       = ctrl_reg[DEPTH-1];
    assign data_o       = data_reg[DEPTH-1];
    assign bubble_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a DEPTH=3/CNT_W=4 and a DEPTH=1 instance
// share stimulus; hand-derived expectations are queued and checked after each edge.
module tb_pipe_stage_reg;

    localparam logic [9:0] BC3 = 10'h2A0;
    localparam logic [9:0] BC1 = 10'h015;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, bubble = 1'b0, flush = 1'b0, clr = 1'b0, vin = 1'b0;
    logic [9:0]  cin = '0;
    logic [31:0] din = '0;

    logic        v3, v1;
    logic [9:0]  c3, c1;
    logic [31:0] d3, d1;
    logic [1:0]  o3;
    logic        o1;
    logic [3:0]  n3;
    logic [15:0] n1;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(10), .DEPTH(3), .BUBBLE_CTRL(BC3), .CNT_W(4)) u_d3 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble), .flush_i(flush),
        .cnt_clr_i(clr), .valid_i(vin), .ctrl_i(cin), .data_i(din),
        .valid_o(v3), .ctrl_o(c3), .data_o(d3), .occ_o(o3), .bubble_cnt_o(n3)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(10), .DEPTH(1), .BUBBLE_CTRL(BC1), .CNT_W(16)) u_d1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble), .flush_i(flush),
        .cnt_clr_i(clr), .valid_i(vin), .ctrl_i(cin), .data_i(din),
        .valid_o(v1), .ctrl_o(c1), .data_o(d1), .occ_o(o1), .bubble_cnt_o(n1)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic        v;
        logic [9:0]  ctrl;
        logic [31:0] data;
        logic [2:0]  occ;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total  = 0;
    int    passes = 0;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, exp);
    endtask

    task automatic push_exp(input logic [1:0] sel, input string t, input logic v,
                            input logic [9:0] c, input logic [31:0] d,
                            input logic [2:0] occ, input logic [15:0] cnt);
        exp_t e;
        e.sel = sel; e.v = v; e.ctrl = c; e.data = d; e.occ = occ; e.cnt = cnt;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.sel == 2'd3) begin
                chk({t, ".d3.valid"}, 32'(v3), 32'(e.v));
                chk({t, ".d3.ctrl"},  32'(c3), 32'(e.ctrl));
                chk({t, ".d3.data"},  d3,      e.data);
                chk({t, ".d3.occ"},   32'(o3), 32'(e.occ));
                chk({t, ".d3.cnt"},   32'(n3), 32'(e.cnt));
            end else begin
                chk({t, ".d1.valid"}, 32'(v1), 32'(e.v));
                chk({t, ".d1.ctrl"},  32'(c1), 32'(e.ctrl));
                chk({t, ".d1.data"},  d1,      e.data);
                chk({t, ".d1.occ"},   32'(o1), 32'(e.occ));
                chk({t, ".d1.cnt"},   32'(n1), 32'(e.cnt));
            end
            $display("check %s done (%0d/%0d)", t, passes, total);
        end
    endtask

    task automatic drive(input logic v, input logic [9:0] c, input logic [31:0] d,
                         input logic st = 1'b0, input logic bu = 1'b0,
                         input logic fl = 1'b0, input logic cl = 1'b0);
        @(negedge clk);
        vin = v; cin = c; din = d; stall = st; bubble = bu; flush = fl; clr = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        push_exp(3, "por", 0, BC3, 0, 0, 0);
        push_exp(1, "por", 0, BC1, 0, 0, 0);
        drain();
        rst = 1'b0;

        // DEPTH=3 latency and fill
        drive(1, 10'h111, 32'h11); push_exp(3, "lat1", 0, BC3, 0, 1, 0); tick();
        drive(1, 10'h122, 32'h22); push_exp(3, "lat2", 0, BC3, 0, 2, 0); tick();
        drive(1, 10'h133, 32'h33); push_exp(3, "lat3", 1, 10'h111, 32'h11, 3, 0); tick();
        drive(1, 10'h144, 32'h44); push_exp(3, "lat4", 1, 10'h122, 32'h22, 3, 0); tick();
        drive(1, 10'h155, 32'h55); push_exp(3, "lat5", 1, 10'h133, 32'h33, 3, 0); tick();
        drive(1, 10'h166, 32'h66, 0, 1); push_exp(3, "bub3", 1, 10'h144, 32'h44, 2, 1); tick();

        // Asynchronous reset asserted mid-cycle, checked before any edge
        #1 rst = 1'b1;
        #1;
        push_exp(3, "arst", 0, BC3, 0, 0, 0);
        push_exp(1, "arst", 0, BC1, 0, 0, 0);
        drain();
        #1 rst = 1'b0;

        // Flush beats stall and bubble; counter untouched
        drive(0, 10'h0, 32'h0, 0, 1); push_exp(3, "fbub", 0, BC3, 0, 0, 1); tick();
        drive(1, 10'h161, 32'h61); push_exp(3, "ffill1", 0, BC3, 0, 1, 1); tick();
        drive(1, 10'h162, 32'h62); push_exp(3, "ffill2", 0, BC3, 0, 2, 1); tick();
        drive(1, 10'h163, 32'h63); push_exp(3, "ffill3", 1, 10'h161, 32'h61, 3, 1); tick();
        drive(1, 10'h164, 32'h64, 1, 1, 1); push_exp(3, "flush3", 0, BC3, 0, 0, 1); tick();

        // Counter saturation at 15, then clear beating a same-cycle bubble
        for (int k = 1; k <= 17; k++) begin
            drive(1, 10'h1AB, 32'h77, 0, 1);
            push_exp(3, $sformatf("sat%0d", k), 0, BC3, 0, 0, 16'((1 + k > 15) ? 15 : 1 + k));
            tick();
        end
        drive(1, 10'h1AB, 32'h77, 0, 1, 0, 1); push_exp(3, "clrbub", 0, BC3, 0, 0, 0); tick();

        // Fresh reset for the DEPTH=1 scenarios
        drive(0, 10'h0, 32'h0);
        rst = 1'b1;
        #1;
        push_exp(1, "rst1", 0, BC1, 0, 0, 0);
        drain();
        #1 rst = 1'b0;

        drive(1, 10'h101, 32'hAAAA); push_exp(1, "cap", 1, 10'h101, 32'hAAAA, 1, 0); tick();
        drive(1, 10'h102, 32'hBBBB, 1); push_exp(1, "stall1", 1, 10'h101, 32'hAAAA, 1, 0); tick();
        drive(1, 10'h102, 32'hBBBB, 1); push_exp(1, "stall2", 1, 10'h101, 32'hAAAA, 1, 0); tick();
        drive(1, 10'h102, 32'hBBBB); push_exp(1, "unstall", 1, 10'h102, 32'hBBBB, 1, 0); tick();
        drive(1, 10'h3FF, 32'hCCCC, 0, 1); push_exp(1, "lu_bub", 0, BC1, 0, 0, 1); tick();
        drive(1, 10'h3FF, 32'hCCCC, 1, 1); push_exp(1, "st_bu", 0, BC1, 0, 0, 1); tick();
        drive(1, 10'h103, 32'h1234); push_exp(1, "cap2", 1, 10'h103, 32'h1234, 1, 1); tick();
        drive(0, 10'h155, 32'hDEADBEEF); push_exp(1, "vin0", 0, BC1, 0, 0, 1); tick();
        drive(1, 10'h104, 32'h5678); push_exp(1, "cap3", 1, 10'h104, 32'h5678, 1, 1); tick();
        drive(1, 10'h105, 32'h9ABC, 0, 0, 1); push_exp(1, "flush1", 0, BC1, 0, 0, 1); tick();
        drive(0, 10'h0, 32'h0, 0, 0, 0, 1); push_exp(1, "clr1", 0, BC1, 0, 0, 0); tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
